// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the 2x2 pooling window feeder.
package pool_pkg;

    localparam int unsigned POOL_DATA_W = 32;
    localparam int unsigned POOL_IMG_W  = 8;
    localparam int unsigned POOL_IMG_H  = 8;

    typedef struct packed {
        logic [POOL_DATA_W-1:0] a;
        logic [POOL_DATA_W-1:0] b;
        logic [POOL_DATA_W-1:0] c;
        logic [POOL_DATA_W-1:0] d;
    } pool_win_t;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_row_buf.sv
// One-row activation buffer: single write port, single read address that
// returns the even/odd column pair containing that address.
module pool_row_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rd_even,
    output logic [DATA_W-1:0] rd_odd
);

    localparam logic [ADDR_W-1:0] PAIR_MASK = ~ADDR_W'(1);

    logic [DATA_W-1:0] mem [IMG_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd_even = mem[raddr & PAIR_MASK];
    assign rd_odd  = mem[raddr | ADDR_W'(1)];

endmodule

// File: rtl/pool_window_2x2.sv
// Raster-stream to non-overlapping 2x2 window converter feeding the max-pool stage.
// Optional win_last output enabled by defining POOL_WIN_LAST_EN.
module pool_window_2x2
    import pool_pkg::*;
#(
    parameter int unsigned DATA_W = POOL_DATA_W,
    parameter int unsigned IMG_W  = POOL_IMG_W,
    parameter int unsigned IMG_H  = POOL_IMG_H
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    output logic [DATA_W-1:0] win_a,
    output logic [DATA_W-1:0] win_b,
    output logic [DATA_W-1:0] win_c,
    output logic [DATA_W-1:0] win_d,
    output logic              win_valid,
`ifdef POOL_WIN_LAST_EN
    output logic              win_last,
`endif
    input  logic              win_ready
);

    localparam int unsigned COL_W = cnt_w(IMG_W);
    localparam int unsigned ROW_W = cnt_w(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0]  col, eff_col, col_nxt;
    logic [ROW_W-1:0]  row, eff_row, row_nxt;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] top_l, top_r;
    logic              accept, odd_row, load, buf_we;
    pool_win_t         win_q;

    assign in_ready = !win_valid || win_ready;
    assign accept   = in_valid && in_ready;

    // Start-of-frame relabels the incoming pixel as (0,0).
    always_comb begin
        eff_col = in_sof ? '0 : col;
        eff_row = in_sof ? '0 : row;
        col_nxt = col;
        row_nxt = row;
        if (accept) begin
            if (eff_col == COL_LAST) begin
                col_nxt = '0;
                row_nxt = (eff_row == ROW_LAST) ? '0 : eff_row + ROW_W'(1);
            end else begin
                col_nxt = eff_col + COL_W'(1);
                row_nxt = eff_row;
            end
        end
    end

    assign odd_row = eff_row[0];
    assign buf_we  = accept && !odd_row;
    assign load    = accept && odd_row && eff_col[0];

    pool_row_buf #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .ADDR_W (COL_W)
    ) u_row_buf (
        .clk     (clk),
        .we      (buf_we),
        .waddr   (eff_col),
        .wdata   (in_data),
        .raddr   (col),
        .rd_even (top_l),
        .rd_odd  (top_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            hold      <= '0;
            win_q     <= '0;
            win_valid <= 1'b0;
        end else begin
            col <= col_nxt;
            row <= row_nxt;
            if (accept && odd_row && !eff_col[0]) begin
                hold <= in_data;
            end
            // A newly completed window takes priority over the transfer clear.
            if (load) begin
                win_q.a   <= POOL_DATA_W'(top_l);
                win_q.b   <= POOL_DATA_W'(top_r);
                win_q.c   <= POOL_DATA_W'(hold);
                win_q.d   <= POOL_DATA_W'(in_data);
                win_valid <= 1'b1;
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

`ifdef POOL_WIN_LAST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_last <= 1'b0;
        end else if (load) begin
            win_last <= (eff_row == ROW_LAST) && (eff_col == COL_LAST);
        end
    end
`endif

    assign win_a = DATA_W'(win_q.a);
    assign win_b = DATA_W'(win_q.b);
    assign win_c = DATA_W'(win_q.c);
    assign win_d = DATA_W'(win_q.d);

endmodule

// File: tb/tb_pool_window_2x2.sv
// Self-checking bench for pool_window_2x2: cycle tables plus model-checked streams.
module tb_pool_window_2x2;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic        last;
    } tw_t;

    typedef struct {
        logic [31:0] d;
        logic        v;
        logic        wr;
        logic        exp_rdy;
        logic        exp_wv;
        logic [31:0] ea, eb, ec, ed;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid, in_sof, win_ready;

    logic        rdy_s, rdy_b, rdy_l;
    logic        wv_s, wv_b, wv_l;
    logic        last_s, last_b, last_l;
    logic [31:0] a_s, b_s, c_s, d_s;
    logic [31:0] a_b, b_b, c_b, d_b;
    logic [31:0] a_l, b_l, c_l, d_l;

    int          sel;
    logic        cur_ready, cur_wv, cur_last;
    logic [31:0] cur_a, cur_b, cur_c, cur_d;

    int          n_cmp = 0;
    int          n_err = 0;
    tw_t         got_q[$];
    tw_t         exp_q[$];
    logic [31:0] px_q[$];
    bit          sof_q[$];
    vec_t        vecs[$];

    always #5 clk = ~clk;

    pool_window_2x2 #(.DATA_W(32), .IMG_W(4), .IMG_H(2)) u_small (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(rdy_s), .win_a(a_s), .win_b(b_s), .win_c(c_s), .win_d(d_s),
        .win_valid(wv_s),
`ifdef POOL_WIN_LAST_EN
        .win_last(last_s),
`endif
        .win_ready(win_ready));

    pool_window_2x2 #(.DATA_W(32), .IMG_W(8), .IMG_H(8)) u_big (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(rdy_b), .win_a(a_b), .win_b(b_b), .win_c(c_b), .win_d(d_b),
        .win_valid(wv_b),
`ifdef POOL_WIN_LAST_EN
        .win_last(last_b),
`endif
        .win_ready(win_ready));

    pool_window_2x2 #(.DATA_W(32), .IMG_W(4), .IMG_H(4)) u_last (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(rdy_l), .win_a(a_l), .win_b(b_l), .win_c(c_l), .win_d(d_l),
        .win_valid(wv_l),
`ifdef POOL_WIN_LAST_EN
        .win_last(last_l),
`endif
        .win_ready(win_ready));

`ifndef POOL_WIN_LAST_EN
    assign last_s = 1'b0;
    assign last_b = 1'b0;
    assign last_l = 1'b0;
`endif

    always_comb begin
        case (sel)
            1: begin
                cur_ready = rdy_b; cur_wv = wv_b; cur_last = last_b;
                cur_a = a_b; cur_b = b_b; cur_c = c_b; cur_d = d_b;
            end
            2: begin
                cur_ready = rdy_l; cur_wv = wv_l; cur_last = last_l;
                cur_a = a_l; cur_b = b_l; cur_c = c_l; cur_d = d_l;
            end
            default: begin
                cur_ready = rdy_s; cur_wv = wv_s; cur_last = last_s;
                cur_a = a_s; cur_b = b_s; cur_c = c_s; cur_d = d_s;
            end
        endcase
    end

    // Window transfers observed mid-cycle, when inputs and outputs are stable.
    always @(negedge clk) begin
        if (!rst && cur_wv && win_ready) begin
            got_q.push_back('{cur_a, cur_b, cur_c, cur_d, cur_last});
        end
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; win_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        got_q.delete(); px_q.delete(); sof_q.delete();
    endtask

    // Offers one pixel with optional leading gaps and random consumer stalls.
    task automatic push(input logic [31:0] d, input logic s, input int gap_pct, input int stall_pct);
        int   n;
        logic acc;
        n = 0;
        while (n < 3 && $urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            win_ready = ($urandom_range(99) >= stall_pct);
            @(posedge clk); #1;
            n++;
        end
        in_data = d; in_sof = s; in_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 64) begin
            win_ready = ($urandom_range(99) >= stall_pct);
            #1 acc = cur_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) begin
            n_cmp++; n_err++;
            $display("FAIL push_timeout: pixel %0d never accepted, required acceptance", d);
        end
        px_q.push_back(d);
        sof_q.push_back(s);
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0; win_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Reference: place each accepted pixel by its raster index, restart index on sof.
    task automatic build_exp(input int w, input int h);
        logic [31:0] img [0:7][0:7];
        int p, r, c;
        p = 0;
        exp_q.delete();
        foreach (px_q[i]) begin
            if (sof_q[i]) p = 0;
            r = p / w;
            c = p % w;
            img[r][c] = px_q[i];
            if ((r % 2 == 1) && (c % 2 == 1)) begin
`ifdef POOL_WIN_LAST_EN
                exp_q.push_back('{img[r-1][c-1], img[r-1][c], img[r][c-1], img[r][c],
                                  (r == h - 1) && (c == w - 1)});
`else
                exp_q.push_back('{img[r-1][c-1], img[r-1][c], img[r][c-1], img[r][c], 1'b0});
`endif
            end
            p = (p + 1) % (w * h);
        end
    endtask

    task automatic cmp_windows(input string name);
        tw_t g;
        check({name, "_count"}, 160'(got_q.size()), 160'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : '0;
            check($sformatf("%s_win%0d", name, i), 160'(g), 160'(exp_q[i]));
        end
    endtask

    function automatic vec_t mk(input logic [31:0] d, input logic v, input logic wr,
                                input logic rdy, input logic wv,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic [31:0] ec, input logic [31:0] ed);
        vec_t x;
        x.d = d; x.v = v; x.wr = wr; x.exp_rdy = rdy; x.exp_wv = wv;
        x.ea = ea; x.eb = eb; x.ec = ec; x.ed = ed;
        return x;
    endfunction

    initial begin
        sel = 0;
        do_reset();
        check("reset_wv", 160'(cur_wv), 160'(1'b0));
        check("reset_win", 160'({cur_a, cur_b, cur_c, cur_d}), 160'(0));
        check("reset_rdy", 160'(cur_ready), 160'(1'b1));

        // 4x2 frame with no stalls, then again with a 3-cycle consumer stall.
        for (int i = 1; i <= 5; i++) vecs.push_back(mk(32'(i), 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(6, 1, 1, 1, 1, 1, 2, 5, 6));
        vecs.push_back(mk(7, 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8, 1, 1, 1, 1, 3, 4, 7, 8));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 5; i++) vecs.push_back(mk(32'(i), 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(6, 1, 1, 1, 1, 1, 2, 5, 6));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(7, 1, 0, 0, 1, 1, 2, 5, 6));
        vecs.push_back(mk(7, 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8, 1, 1, 1, 1, 3, 4, 7, 8));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            in_data = vecs[i].d; in_valid = vecs[i].v; in_sof = 1'b0; win_ready = vecs[i].wr;
            #1 check($sformatf("tbl%0d_in_ready", i), 160'(cur_ready), 160'(vecs[i].exp_rdy));
            @(posedge clk); #1;
            check($sformatf("tbl%0d_win_valid", i), 160'(cur_wv), 160'(vecs[i].exp_wv));
            if (vecs[i].exp_wv)
                check($sformatf("tbl%0d_window", i), 160'({cur_a, cur_b, cur_c, cur_d}),
                      160'({vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].ed}));
        end
        in_valid = 1'b0;

        // Start of frame on the third pixel restarts the raster position.
        do_reset();
        for (int i = 1; i <= 10; i++) push(32'(i), i == 3, 30, 20);
        drain();
        build_exp(4, 2);
        cmp_windows("sof");
        check("sof_first", (got_q.size() > 0) ? 160'(got_q[0]) : 160'(0),
              160'(tw_t'({32'd3, 32'd4, 32'd7, 32'd8, 1'b0})));

        // Asynchronous reset while a window is held and the row is half done.
        do_reset();
        for (int i = 1; i <= 6; i++) push(32'(i), 0, 0, 100);
        check("rst_pre_wv", 160'(cur_wv), 160'(1'b1));
        #2 rst = 1'b1;
        #1 check("rst_async_wv", 160'(cur_wv), 160'(1'b0));
        check("rst_async_win", 160'({cur_a, cur_b, cur_c, cur_d}), 160'(0));
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        got_q.delete(); px_q.delete(); sof_q.delete();
        for (int i = 11; i <= 18; i++) push(32'(i), 0, 30, 30);
        drain();
        build_exp(4, 2);
        cmp_windows("post_rst");

        // Two back-to-back random 8x8 frames with gaps and back-pressure.
        sel = 1;
        do_reset();
        for (int i = 0; i < 128; i++) push($urandom, i == 0, 30, 30);
        drain();
        build_exp(8, 8);
        check("rand_total", 160'(got_q.size()), 160'(32));
        cmp_windows("rand");

        // 4x4 frame: only the final window carries the frame-end marker.
        sel = 2;
        do_reset();
        for (int i = 0; i < 16; i++) push(32'(100 + i), i == 0, 20, 20);
        drain();
        build_exp(4, 4);
        cmp_windows("frame4x4");
`ifdef POOL_WIN_LAST_EN
        for (int i = 0; i < 4; i++)
            check($sformatf("last_flag%0d", i), (i < got_q.size()) ? 160'(got_q[i].last) : 160'(1'bx),
                  160'(i == 3));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pool_window_2x2.md
Name: pool_window_2x2

Overview:
- Upstream feeder for the 4-input max-pooling stage.
- Accepts a raster-order stream of 32-bit activations and buffers one image row.
- Emits non-overlapping 2x2 windows (stride 2) as four parallel words plus a valid strobe, which drives the pooling stage's en input.
- Provides a valid/ready handshake on both sides so it can stall an upstream conv/ReLU stage.

Parameters:
- DATA_W, 32, width of each activation word.
- IMG_W, 8, image width in pixels; must be even and at least 2.
- IMG_H, 8, image height in rows; must be even and at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  pixel value, raster order.
- in_valid  input  1  in_data is valid.
- in_sof  input  1  start of frame; qualified by in_valid.
- in_ready  output  1  block accepts the pixel this cycle.
- win_a  output  DATA_W  pixel (r, c), top-left.
- win_b  output  DATA_W  pixel (r, c+1), top-right.
- win_c  output  DATA_W  pixel (r+1, c), bottom-left.
- win_d  output  DATA_W  pixel (r+1, c+1), bottom-right.
- win_valid  output  1  window registers hold a valid window; connects to the pooling en.
- win_ready  input  1  consumer takes the window; tie high for the pooling stage.

Behaviour:
- Handshake:
  - A pixel is accepted when in_valid and in_ready are both high.
  - in_ready = !win_valid || win_ready (combinational).
  - A window transfers when win_valid and win_ready are both high.
- State:
  - col counter 0..IMG_W-1 and row counter 0..IMG_H-1.
  - Row buffer of IMG_W entries.
  - One hold register for the bottom-left pixel.
  - Output registers win_a..win_d and win_valid.
- Reset: col=0, row=0, win_valid=0, win_a..win_d=0. Row buffer contents are don't-care.
- Accepted pixel on an even row: written to rowbuf[col]. No output.
- Accepted pixel on an odd row, even col: stored in the hold register.
- Accepted pixel on an odd row, odd col:
  - Next cycle, win_a=rowbuf[col-1], win_b=rowbuf[col], win_c=hold, win_d=in_data, win_valid=1.
  - Latency is 1 cycle from the completing pixel.
- win_valid clears on transfer unless a new window loads in the same cycle; load has priority.
- Counter advance on each accepted pixel:
  - col increments.
  - At IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0, which is the start of the next frame.
- in_sof on an accepted pixel:
  - Forces this pixel to be treated as (0,0); counters go to col=1, row=0.
  - Any partial window is discarded.
  - A pending valid window in the output registers is not affected.
- Back-pressure: in_ready is low while an untaken window is held. No pixel is lost or duplicated under any stall pattern.
- Throughput: with win_ready=1, one pixel per cycle sustained, and one window per 4 pixels on average.
- rst asserted mid-frame: all state is cleared immediately and the next accepted pixel is (0,0).

Optional Feature:
- Macro: POOL_WIN_LAST_EN.
- When defined:
  - Adds output win_last (1 bit), registered alongside the window.
  - win_last is high only with the window completed at (IMG_H-1, IMG_W-1). Reset value 0.
- When undefined: the port is absent and there is no extra logic.

Decomposition:
- Shared package pool_pkg holds:
  - the DATA_W default;
  - a packed window typedef pool_win_t with fields a, b, c, d;
  - localparam helpers for the col/row counter widths ($clog2 of IMG_W and IMG_H).
- One natural sub-module, pool_row_buf: a single-port-write, single-port-read IMG_W x DATA_W register array with the read address driven from col.

Test Plan:
- IMG_W=4, IMG_H=2, pixels 1..8, win_ready=1, no gaps:
  - windows {1,2,5,6} and {3,4,7,8};
  - win_valid is high one cycle after pixels 6 and 8.
- Same frame with win_ready low for 3 cycles after the first window:
  - in_ready low during the stall;
  - second window unchanged; no pixel lost.
- Random in_valid gaps over two back-to-back 8x8 frames: 32 windows total, all matching the reference max-input model.
- in_sof asserted on pixel 3 of a frame:
  - counters restart; the pixel is treated as (0,0);
  - the first window formed uses pixels 3, 4, 3+IMG_W, 4+IMG_W.
- rst pulsed mid-row:
  - win_valid=0 and win_a..d=0 immediately;
  - the following frame produces correct windows.
- POOL_WIN_LAST_EN defined, 4x4 frame: win_last high only on the 4th window.
